midi_hex_formatter: RTL and testbench
=====================================

Name: midi_hex_formatter

Overview:
- Parses a raw MIDI byte stream into complete channel-voice messages.
- Drives six single-digit hex segment decoders (one nibble plus valid strobe per digit) so the last received message appears as six hex digits: SS D1 D2.
- Sits between the MIDI UART byte receiver and the per-digit segment decoders.
- Rate-limits display updates so a human can read them; when a newer message is waiting, the latest one wins.

Parameters:
- HOLD_CYCLES, 5_000_000, minimum clk cycles a message stays displayed before the next update (100 ms at 50 MHz); 0 disables hold.
- NUM_DIGITS, 6, digit count; fixed at 6, any other value is a compile-time error.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- byte_in  input  8  MIDI byte from UART receiver
- byte_valid  input  1  byte_in valid this cycle; every byte is accepted (no backpressure)
- nibble_out  output  24  digit i nibble on [4i+3:4i]; digit 5 = status hi … digit 0 = data2 lo
- valid_out  output  6  one-cycle update strobe for digit i
- busy  output  1  high in EMIT or HOLD

Behaviour:
- Reset values: nibble_out=0, valid_out=0, busy=0, running status cleared, pending empty, FSM=IDLE, parser byte count=0. Reset has priority over all other events.
- Parser (runs every cycle byte_valid=1, independent of FSM):
  - 0xF8–0xFF (realtime): ignored. No effect on running status or a partial message.
  - 0xF0–0xF7: clears running status and partial message. Following data bytes are discarded until the next 0x80–0xEF status byte.
  - 0x80–0xEF: sets running status and clears partial data. Needed data bytes: 1 for 0xC_/0xD_, 2 for all others.
  - 0x00–0x7F with valid running status: stored as D1, then D2. When the needed count is reached the message is complete and the count resets, keeping running status.
  - 0x00–0x7F with no running status: discarded.
- Completed message: written to the one-deep pending buffer on the same edge that samples the final byte (pend_valid=1). A 1-data-byte message stores D2=0x00. A newer completion overwrites an unconsumed pending entry.
- FSM IDLE:
  - If pend_valid: copy pending into the display register, clear pend_valid, go to EMIT with digit index 5.
  - If a completion and a consume happen on the same edge, the new message remains pending (pend_valid stays 1).
- FSM EMIT:
  - Each cycle, register nibble_out[index] = the display nibble and valid_out[index]=1 (one-hot). Other nibbles hold their values.
  - Index decrements 5→0.
  - After index 0: go to HOLD with counter=HOLD_CYCLES-1, or to IDLE if HOLD_CYCLES=0.
- FSM HOLD: decrement counter each cycle; at 0 go to IDLE. The parser and pending buffer keep running.
- Latency: edge N samples the final byte → edge N+1 leaves IDLE → valid_out[5] is high after edge N+2 → valid_out[0] is high after edge N+7.
- Spacing: strobes of consecutive displayed messages begin at least 6+HOLD_CYCLES+1 cycles apart.
- Counter width: $clog2(HOLD_CYCLES+1), minimum 1.
- Reset mid-EMIT/HOLD: next cycle all outputs are 0 and no further strobes occur. Bytes sampled on the reset edge are discarded.

Decomposition:
- Package midi_pkg: status range constants (MIDI_SYSEX=8'hF0, MIDI_RT_MIN=8'hF8), FSM state enum {IDLE, EMIT, HOLD}, and a packed midi_msg_t {status, d1, d2}.
- Sub-module midi_msg_parser holds the running-status byte parser (byte_in/byte_valid → msg_t + msg_done pulse). The top contains the pending buffer, FSM and hold counter.

Test Plan:
- Note on: reset, then 0x90,0x3C,0x64 → valid_out 6'b100000..6'b000001 on consecutive cycles from edge N+2; nibbles 9,0,3,C,6,4; nibble_out=24'h903C64 afterwards.
- Running status, HOLD_CYCLES=0: 0x90,0x3C,0x64,0x3E,0x00 → two updates; final nibble_out=24'h903E00.
- 1-byte message and realtime interleave:
  - 0xC5,0x07 → 24'hC50700.
  - 0x80,0xF8,0x40,0xFE,0x00 → 24'h804000.
- Sysex discard:
  - 0xF0,0x40,0x41,0xF7 → no valid_out strobes, busy stays 0.
  - A following 0x40 (no running status) is also ignored.
- Latest-wins, HOLD_CYCLES=20: 0x90,0x3C,0x64 then, during HOLD, 0x90,0x3D,0x64 and 0x90,0x3E,0x64 → exactly two updates, 24'h903C64 then 24'h903E64; the second begins ≥27 cycles after the first.
- Reset mid-EMIT (after valid_out[3]) → next cycle valid_out=0, nibble_out=0, busy=0, no further strobes. A subsequent bare 0x3C is ignored.

Source files
------------

// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : midi_pkg
// Description : Shared MIDI constants, FSM state type and message record.
// Revision    : 1.0 - initial release
// ============================================================================
package midi_pkg;

    localparam logic [7:0] MIDI_STATUS_MIN = 8'h80;
    localparam logic [7:0] MIDI_SYSEX      = 8'hF0;
    localparam logic [7:0] MIDI_RT_MIN     = 8'hF8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        HOLD = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] d1;
        logic [7:0] d2;
    } midi_msg_t;

    // Program change and channel pressure carry a single data byte.
    function automatic logic needs_one_byte(input logic [7:0] status);
        return (status[7:4] == 4'hC) || (status[7:4] == 4'hD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_msg_parser.sv
`default_nettype none
// ============================================================================
// Module      : midi_msg_parser
// Description : Running-status MIDI byte parser; pulses msg_done combinationally
//               in the cycle the final data byte is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module midi_msg_parser
    import midi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output midi_msg_t  msg,
    output logic       msg_done
);

    logic [7:0] status_q, status_d;
    logic       rs_valid_q, rs_valid_d;
    logic       cnt_q, cnt_d;
    logic [7:0] d1_q, d1_d;

    always_comb begin
        status_d   = status_q;
        rs_valid_d = rs_valid_q;
        cnt_d      = cnt_q;
        d1_d       = d1_q;
        msg_done   = 1'b0;
        msg        = '{status: status_q, d1: d1_q, d2: 8'h00};

        if (byte_valid) begin
            if (byte_in >= MIDI_RT_MIN) begin
                // realtime bytes are transparent to parsing
            end else if (byte_in >= MIDI_SYSEX) begin
                rs_valid_d = 1'b0;
                cnt_d      = 1'b0;
            end else if (byte_in >= MIDI_STATUS_MIN) begin
                status_d   = byte_in;
                rs_valid_d = 1'b1;
                cnt_d      = 1'b0;
            end else if (rs_valid_q) begin
                if (cnt_q == 1'b0) begin
                    if (needs_one_byte(status_q)) begin
                        msg_done = 1'b1;
                        msg      = '{status: status_q, d1: byte_in, d2: 8'h00};
                    end else begin
                        d1_d  = byte_in;
                        cnt_d = 1'b1;
                    end
                end else begin
                    msg_done = 1'b1;
                    msg      = '{status: status_q, d1: d1_q, d2: byte_in};
                    cnt_d    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q   <= 8'h00;
            rs_valid_q <= 1'b0;
            cnt_q      <= 1'b0;
            d1_q       <= 8'h00;
        end else begin
            status_q   <= status_d;
            rs_valid_q <= rs_valid_d;
            cnt_q      <= cnt_d;
            d1_q       <= d1_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/midi_hex_formatter.sv
`default_nettype none
// ============================================================================
// Module      : midi_hex_formatter
// Description : Shows the latest MIDI channel message as six hex digits with
//               per-digit update strobes and a rate-limiting hold time.
// Revision    : 1.0 - initial release
// ============================================================================
module midi_hex_formatter
    import midi_pkg::*;
#(
    parameter int HOLD_CYCLES = 5_000_000,
    parameter int NUM_DIGITS  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    output logic [4*NUM_DIGITS-1:0] nibble_out,
    output logic [NUM_DIGITS-1:0]   valid_out,
    output logic                    busy
);

    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

    generate
        if (NUM_DIGITS != 6) begin : g_bad_digits
            $error("midi_hex_formatter: NUM_DIGITS must be 6");
        end
    endgenerate

    midi_msg_t parsed_msg;
    logic      parsed_done;

    midi_msg_parser u_parser (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .msg        (parsed_msg),
        .msg_done   (parsed_done)
    );

    fsm_state_t                state_q, state_d;
    midi_msg_t                 pend_q, pend_d;
    logic                      pend_valid_q, pend_valid_d;
    midi_msg_t                 disp_q, disp_d;
    logic [2:0]                idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0]   nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0]     valid_q, valid_d;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        disp_d       = disp_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        nibble_d     = nibble_q;
        valid_d      = '0;

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    disp_d       = pend_q;
                    pend_valid_d = 1'b0;
                    idx_d        = 3'd5;
                    state_d      = EMIT;
                end
            end
            EMIT: begin
                nibble_d[{idx_q, 2'b00} +: 4] = disp_q[{idx_q, 2'b00} +: 4];
                valid_d = NUM_DIGITS'(1) << idx_q;
                idx_d   = idx_q - 3'd1;
                if (idx_q == 3'd0) begin
                    if (HOLD_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completion on the consume edge must survive as the new pending entry.
        if (parsed_done) begin
            pend_d       = parsed_msg;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            disp_q       <= '0;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            nibble_q     <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            disp_q       <= disp_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            nibble_q     <= nibble_d;
            valid_q      <= valid_d;
        end
    end

    assign nibble_out = nibble_q;
    assign valid_out  = valid_q;
    assign busy       = (state_q == EMIT) || (state_q == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_midi_hex_formatter.sv
`default_nettype none
// ============================================================================
// Module      : tb_midi_hex_formatter
// Description : Directed bench for midi_hex_formatter (hold 0 and hold 20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_hex_formatter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;

    logic [23:0] nib0, nib20;
    logic [5:0]  val0, val20;
    logic        busy0, busy20;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int s0_v5 = 0;
    int s0_any = 0;
    int s20_v5 = 0;
    int s20_t[0:15];
    logic busy_seen = 1'b0;

    midi_hex_formatter #(.HOLD_CYCLES(0), .NUM_DIGITS(6)) u_dut0 (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .nibble_out(nib0), .valid_out(val0), .busy(busy0)
    );

    midi_hex_formatter #(.HOLD_CYCLES(20), .NUM_DIGITS(6)) u_dut20 (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .nibble_out(nib20), .valid_out(val20), .busy(busy20)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (val0[5]) s0_v5 = s0_v5 + 1;
        if (val0 != 6'd0) s0_any = s0_any + 1;
        if (busy0) busy_seen = 1'b1;
        if (val20[5]) begin
            s20_t[s20_v5 % 16] = cyc;
            s20_v5 = s20_v5 + 1;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [3:0] exp_nib [0:5];
    int base0, base_any, base20;
    bit found;

    initial begin
        exp_nib[0] = 4'h9; exp_nib[1] = 4'h0; exp_nib[2] = 4'h3;
        exp_nib[3] = 4'hC; exp_nib[4] = 4'h6; exp_nib[5] = 4'h4;

        // Reset state
        do_reset();
        chk_eq("rst_nibble", 32'(nib0), 32'h0);
        chk_eq("rst_valid",  32'(val0), 32'h0);
        chk_eq("rst_busy",   32'(busy0), 32'h0);

        // Note on: exact strobe timing and nibble order
        send(8'h90); send(8'h3C); send(8'h64);
        idle(1);
        chk_eq("t1_n_valid", 32'(val0), 32'h0);
        chk_eq("t1_n_busy",  32'(busy0), 32'h0);
        @(negedge clk);
        chk_eq("t1_n1_valid", 32'(val0), 32'h0);
        chk_eq("t1_n1_busy",  32'(busy0), 32'h1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_eq($sformatf("t1_strobe%0d", k), 32'(val0), 32'(6'b100000 >> k));
            chk_eq($sformatf("t1_nib%0d", k), 32'(nib0[(5 - k) * 4 +: 4]), 32'(exp_nib[k]));
        end
        idle(2);
        chk_eq("t1_final", 32'(nib0), 32'h903C64);
        chk_eq("t1_final20", 32'(nib20), 32'h903C64);

        // Running status with no hold
        do_reset();
        base0 = s0_v5;
        send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h00);
        idle(30);
        chk_eq("t2_updates", 32'(s0_v5 - base0), 32'd2);
        chk_eq("t2_final", 32'(nib0), 32'h903E00);

        // One-data-byte message, then realtime interleave
        do_reset();
        base0 = s0_v5;
        send(8'hC5); send(8'h07);
        idle(15);
        chk_eq("t3_pc_nib", 32'(nib0), 32'hC50700);
        chk_eq("t3_pc_upd", 32'(s0_v5 - base0), 32'd1);
        base0 = s0_v5;
        send(8'h80); send(8'hF8); send(8'h40); send(8'hFE); send(8'h00);
        idle(15);
        chk_eq("t3_rt_nib", 32'(nib0), 32'h804000);
        chk_eq("t3_rt_upd", 32'(s0_v5 - base0), 32'd1);

        // Sysex cancels running status; bare data afterwards is dropped
        do_reset();
        base_any  = s0_any;
        busy_seen = 1'b0;
        send(8'h90); send(8'hF0); send(8'h40); send(8'h41); send(8'hF7);
        idle(12);
        chk_eq("t4_strobes", 32'(s0_any - base_any), 32'd0);
        chk_eq("t4_busy", 32'(busy_seen), 32'd0);
        send(8'h40);
        idle(12);
        chk_eq("t4_bare_strobes", 32'(s0_any - base_any), 32'd0);
        chk_eq("t4_bare_nib", 32'(nib0), 32'h0);

        // Latest wins during hold
        do_reset();
        base20 = s20_v5;
        send(8'h90); send(8'h3C); send(8'h64);
        idle(10);
        chk_eq("t5_first_nib", 32'(nib20), 32'h903C64);
        chk_eq("t5_first_busy", 32'(busy20), 32'h1);
        send(8'h90); send(8'h3D); send(8'h64);
        send(8'h90); send(8'h3E); send(8'h64);
        idle(60);
        chk_eq("t5_updates", 32'(s20_v5 - base20), 32'd2);
        chk_eq("t5_spacing", 32'(s20_t[(base20 + 1) % 16] - s20_t[base20 % 16]), 32'd27);
        chk_eq("t5_final", 32'(nib20), 32'h903E64);

        // Reset in the middle of EMIT
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64);
        idle(1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (val0[3]) found = 1'b1;
            else @(negedge clk);
        end
        chk_eq("t6_saw_digit3", 32'(found), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk_eq("t6_valid", 32'(val0), 32'h0);
        chk_eq("t6_nib",   32'(nib0), 32'h0);
        chk_eq("t6_busy",  32'(busy0), 32'h0);
        reset = 1'b0;
        base_any = s0_any;
        idle(15);
        chk_eq("t6_no_strobes", 32'(s0_any - base_any), 32'd0);
        send(8'h3C);
        idle(15);
        chk_eq("t6_bare_strobes", 32'(s0_any - base_any), 32'd0);
        chk_eq("t6_bare_nib", 32'(nib0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
